egr_wadj_drop_ctrl: RTL and testbench

//  Egress width-adjust packet admission stage; consumes cfg_drop_en / cfg_drop_threshold from the egress wadj CSR block.

---
 rtl/egr_wadj_drop_ctrl.sv | 119 +++++++++++
 tb/tb_egr_wadj_drop_ctrl.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/egr_wadj_drop_ctrl.sv
// Egress width-adjust admission stage: drops whole packets at SOP when the downstream
// FIFO fill reaches the CSR threshold, forwards passed beats through one output register.
module egr_wadj_drop_ctrl #(
    parameter int DATA_WIDTH  = 512,
    parameter int EMPTY_WIDTH = 6,
    parameter int FILL_WIDTH  = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cfg_drop_en,
    input  logic [15:0]            cfg_drop_threshold,
    input  logic [FILL_WIDTH-1:0]  fifo_fill_level,
    input  logic                   i_valid,
    output logic                   i_ready,
    input  logic [DATA_WIDTH-1:0]  i_data,
    input  logic                   i_sop,
    input  logic                   i_eop,
    input  logic [EMPTY_WIDTH-1:0] i_empty,
    output logic                   o_valid,
    input  logic                   o_ready,
    output logic [DATA_WIDTH-1:0]  o_data,
    output logic                   o_sop,
    output logic                   o_eop,
    output logic [EMPTY_WIDTH-1:0] o_empty,
    output logic [31:0]            stat_drop_pkt_cnt,
    output logic                   stat_drop_pulse,
    output logic                   stat_proto_err
);

    typedef enum logic [1:0] {ST_IDLE, ST_PASS, ST_DROP} state_t;

    // A wider fill level would be silently truncated by the zero-extending cast below.
    if (FILL_WIDTH > 16) begin : g_fill_width_chk
        $error("egr_wadj_drop_ctrl: FILL_WIDTH must be <= 16");
    end

    state_t                   r_state;
    logic                     r_valid;
    logic [DATA_WIDTH-1:0]    r_data;
    logic                     r_sop;
    logic                     r_eop;
    logic [EMPTY_WIDTH-1:0]   r_empty;
    logic [31:0]              r_drop_cnt;
    logic                     r_drop_pulse;
    logic                     r_proto_err;

    logic [15:0] w_fill_ext;
    logic        w_accept;
    logic        w_drop_hit;
    logic        w_drop_new;
    logic        w_pass_beat;
    logic        w_proto_err;

    // The drop sink never stalls; otherwise accept only when the output slot frees up.
    assign i_ready     = rst_n & ((r_state == ST_DROP) | ~r_valid | o_ready);
    assign w_accept    = i_valid & i_ready;
    assign w_fill_ext  = 16'(fifo_fill_level);
    assign w_drop_hit  = cfg_drop_en & (w_fill_ext >= cfg_drop_threshold);
    assign w_drop_new  = w_accept & i_sop & w_drop_hit;
    assign w_pass_beat = w_accept & (i_sop ? ~w_drop_hit : (r_state == ST_PASS));
    assign w_proto_err = w_accept & ((i_sop & (r_state != ST_IDLE)) |
                                     (~i_sop & (r_state == ST_IDLE)));

    // NOTE: every register here is updated with <= so all reads see pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_valid      <= 1'b0;
            // NOTE: the data path is reset too, so o_data reads zero after reset.
            r_data       <= '0;
            r_sop        <= 1'b0;
            r_eop        <= 1'b0;
            r_empty      <= '0;
            r_drop_cnt   <= '0;
            r_drop_pulse <= 1'b0;
            r_proto_err  <= 1'b0;
        end else begin
            r_drop_pulse <= w_drop_new;
            r_proto_err  <= w_proto_err;

            if (w_drop_new && (r_drop_cnt != 32'hFFFF_FFFF)) begin
                r_drop_cnt <= r_drop_cnt + 32'd1;
            end

            if (w_pass_beat) begin
                r_valid <= 1'b1;
                r_data  <= i_data;
                r_sop   <= i_sop;
                r_eop   <= i_eop;
                r_empty <= i_empty;
            end else if (o_ready) begin
                r_valid <= 1'b0;
            end

            // Any accepted SOP re-decides, even mid-packet after a missing EOP.
            if (w_accept) begin
                if (i_sop) begin
                    if (i_eop) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_state <= w_drop_hit ? ST_DROP : ST_PASS;
                    end
                end else if (i_eop && (r_state != ST_IDLE)) begin
                    r_state <= ST_IDLE;
                end
            end
        end
    end

    assign o_valid           = r_valid;
    assign o_data            = r_data;
    assign o_sop             = r_sop;
    assign o_eop             = r_eop;
    assign o_empty           = r_empty;
    assign stat_drop_pkt_cnt = r_drop_cnt;
    assign stat_drop_pulse   = r_drop_pulse;
    assign stat_proto_err    = r_proto_err;

endmodule

// File: tb/tb_egr_wadj_drop_ctrl.sv
// Directed bench for egr_wadj_drop_ctrl: pass/drop decisions, framing errors,
// backpressure stability, counter saturation and mid-packet reset.
module tb_egr_wadj_drop_ctrl;

    localparam int DW = 512;
    localparam int EW = 6;
    localparam int FW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cfg_drop_en;
    logic [15:0]   cfg_drop_threshold;
    logic [FW-1:0] fifo_fill_level;
    logic          i_valid;
    logic          i_ready;
    logic [DW-1:0] i_data;
    logic          i_sop;
    logic          i_eop;
    logic [EW-1:0] i_empty;
    logic          o_valid;
    logic          o_ready;
    logic [DW-1:0] o_data;
    logic          o_sop;
    logic          o_eop;
    logic [EW-1:0] o_empty;
    logic [31:0]   stat_drop_pkt_cnt;
    logic          stat_drop_pulse;
    logic          stat_proto_err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    egr_wadj_drop_ctrl #(.DATA_WIDTH(DW), .EMPTY_WIDTH(EW), .FILL_WIDTH(FW)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .cfg_drop_en        (cfg_drop_en),
        .cfg_drop_threshold (cfg_drop_threshold),
        .fifo_fill_level    (fifo_fill_level),
        .i_valid            (i_valid),
        .i_ready            (i_ready),
        .i_data             (i_data),
        .i_sop              (i_sop),
        .i_eop              (i_eop),
        .i_empty            (i_empty),
        .o_valid            (o_valid),
        .o_ready            (o_ready),
        .o_data             (o_data),
        .o_sop              (o_sop),
        .o_eop              (o_eop),
        .o_empty            (o_empty),
        .stat_drop_pkt_cnt  (stat_drop_pkt_cnt),
        .stat_drop_pulse    (stat_drop_pulse),
        .stat_proto_err     (stat_proto_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_beat(input logic v, input logic sop, input logic eop,
                            input logic [31:0] d, input logic [EW-1:0] e);
        i_valid = v;
        i_sop   = sop;
        i_eop   = eop;
        i_data  = DW'(d);
        i_empty = e;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cfg_drop_en = 1'b0;
        cfg_drop_threshold = 16'd0;
        fifo_fill_level = '0;
        o_ready = 1'b1;
        set_beat(1'b0, 1'b0, 1'b0, 32'h0, '0);
        step();
        step();
        n_tests++;
        if (o_valid !== 1'b0 || o_sop !== 1'b0 || o_eop !== 1'b0 || o_data !== '0 || o_empty !== '0) begin
            n_fail++;
            $display("FAIL reset_out: valid=%b sop=%b eop=%b data=%h empty=%0d, want all 0",
                     o_valid, o_sop, o_eop, o_data[31:0], o_empty);
        end
        n_tests++;
        if (stat_drop_pkt_cnt !== 32'd0 || stat_drop_pulse !== 1'b0 || stat_proto_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_stats: cnt=%h pulse=%b perr=%b, want 0/0/0",
                     stat_drop_pkt_cnt, stat_drop_pulse, stat_proto_err);
        end
        n_tests++;
        if (i_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_iready: got %b want 0", i_ready);
        end
        rst_n = 1'b1;
        #1;
        n_tests++;
        if (i_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset_iready: got %b want 1", i_ready);
        end
    endtask

    task automatic test_pass();
        cfg_drop_en = 1'b0;
        cfg_drop_threshold = 16'd10;
        fifo_fill_level = 16'd100;
        o_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_beat(1'b1, i == 0, i == 3, 32'h100 + i, (i == 3) ? 6'd5 : 6'd0);
            step();
            n_tests++;
            if (o_valid !== 1'b1 || o_data !== DW'(32'h100 + i) || o_sop !== (i == 0) ||
                o_eop !== (i == 3) || o_empty !== ((i == 3) ? 6'd5 : 6'd0)) begin
                n_fail++;
                $display("FAIL pass_beat%0d: valid=%b data=%h sop=%b eop=%b empty=%0d, want 1/%h/%b/%b/%0d",
                         i, o_valid, o_data[31:0], o_sop, o_eop, o_empty, 32'h100 + i,
                         i == 0, i == 3, (i == 3) ? 5 : 0);
            end
        end
        set_beat(1'b0, 1'b0, 1'b0, 32'h0, '0);
        step();
        n_tests++;
        if (o_valid !== 1'b0 || stat_drop_pkt_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL pass_tail: valid=%b cnt=%0d, want 0/0", o_valid, stat_drop_pkt_cnt);
        end
    endtask

    task automatic test_drop();
        cfg_drop_en = 1'b1;
        cfg_drop_threshold = 16'd64;
        fifo_fill_level = 16'd64;
        for (int i = 0; i < 3; i++) begin
            set_beat(1'b1, i == 0, i == 2, 32'h200 + i, '0);
            #1;
            n_tests++;
            if (i_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL drop_iready%0d: got %b want 1", i, i_ready);
            end
            step();
            n_tests++;
            if (o_valid !== 1'b0 || stat_drop_pulse !== (i == 0) || stat_drop_pkt_cnt !== 32'd1) begin
                n_fail++;
                $display("FAIL drop_beat%0d: valid=%b pulse=%b cnt=%0d, want 0/%b/1",
                         i, o_valid, stat_drop_pulse, stat_drop_pkt_cnt, i == 0);
            end
        end
        fifo_fill_level = 16'd63;
        for (int i = 0; i < 2; i++) begin
            set_beat(1'b1, i == 0, i == 1, 32'h210 + i, '0);
            step();
            n_tests++;
            if (o_valid !== 1'b1 || o_data !== DW'(32'h210 + i) || stat_drop_pulse !== 1'b0) begin
                n_fail++;
                $display("FAIL below_thr_beat%0d: valid=%b data=%h pulse=%b, want 1/%h/0",
                         i, o_valid, o_data[31:0], stat_drop_pulse, 32'h210 + i);
            end
        end
        set_beat(1'b0, 1'b0, 1'b0, 32'h0, '0);
        step();
    endtask

    task automatic test_mid_packet_cfg();
        cfg_drop_en = 1'b1;
        cfg_drop_threshold = 16'd64;
        fifo_fill_level = 16'd10;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin
                fifo_fill_level = 16'd500;
                cfg_drop_en = (i % 2) == 1;
            end
            set_beat(1'b1, i == 0, i == 4, 32'h300 + i, '0);
            step();
            n_tests++;
            if (o_valid !== 1'b1 || o_data !== DW'(32'h300 + i) || o_eop !== (i == 4)) begin
                n_fail++;
                $display("FAIL midcfg_beat%0d: valid=%b data=%h eop=%b, want 1/%h/%b",
                         i, o_valid, o_data[31:0], o_eop, 32'h300 + i, i == 4);
            end
        end
        set_beat(1'b0, 1'b0, 1'b0, 32'h0, '0);
        step();
        n_tests++;
        if (stat_drop_pkt_cnt !== 32'd1) begin
            n_fail++;
            $display("FAIL midcfg_cnt: got %0d want 1", stat_drop_pkt_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [33:0] exp_q[$];
        logic [33:0] exp_b;
        logic [33:0] held;
        logic        acc;
        logic        cons;
        logic        hold;
        int          sent = 0;
        int          got = 0;
        int          cyc = 0;
        cfg_drop_en = 1'b0;
        fifo_fill_level = '0;
        while ((sent < 16 || got < 16) && cyc < 2000) begin
            if (sent < 16) begin
                set_beat(1'b1, (sent % 2) == 0, (sent % 2) == 1, 32'h400 + sent, '0);
                o_ready = 1'($urandom_range(0, 1));
            end else begin
                set_beat(1'b0, 1'b0, 1'b0, 32'h0, '0);
                o_ready = 1'b1;
            end
            #1;
            acc  = i_valid & i_ready;
            cons = o_valid & o_ready;
            hold = o_valid & ~o_ready;
            held = {o_sop, o_eop, o_data[31:0]};
            if (cons) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL b2b_extra: got beat %h with nothing expected", held);
                end else begin
                    exp_b = exp_q.pop_front();
                    if (held !== exp_b || o_data[DW-1:32] !== '0) begin
                        n_fail++;
                        $display("FAIL b2b_order: got %h want %h", held, exp_b);
                    end
                end
                got++;
            end
            step();
            if (acc) begin
                exp_q.push_back({i_sop, i_eop, i_data[31:0]});
                sent++;
            end
            if (hold) begin
                n_tests++;
                if (o_valid !== 1'b1 || {o_sop, o_eop, o_data[31:0]} !== held) begin
                    n_fail++;
                    $display("FAIL b2b_stable: valid=%b beat=%h want 1/%h",
                             o_valid, {o_sop, o_eop, o_data[31:0]}, held);
                end
            end
            cyc++;
        end
        n_tests++;
        if (cyc >= 2000 || got != 16 || exp_q.size() != 0 || o_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_done: cycles=%0d got=%0d left=%0d valid=%b, want <2000/16/0/0",
                     cyc, got, exp_q.size(), o_valid);
        end
    endtask

    task automatic test_framing();
        cfg_drop_en = 1'b0;
        o_ready = 1'b1;
        set_beat(1'b1, 1'b0, 1'b0, 32'h500, '0);
        step();
        n_tests++;
        if (stat_proto_err !== 1'b1 || o_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_nosop: perr=%b valid=%b, want 1/0", stat_proto_err, o_valid);
        end
        set_beat(1'b1, 1'b1, 1'b0, 32'h501, '0);
        step();
        n_tests++;
        if (stat_proto_err !== 1'b0 || o_valid !== 1'b1 || o_data !== DW'(32'h501)) begin
            n_fail++;
            $display("FAIL frame_sop: perr=%b valid=%b data=%h, want 0/1/501",
                     stat_proto_err, o_valid, o_data[31:0]);
        end
        set_beat(1'b1, 1'b1, 1'b0, 32'h502, '0);
        step();
        n_tests++;
        if (stat_proto_err !== 1'b1 || o_valid !== 1'b1 || o_data !== DW'(32'h502) || o_sop !== 1'b1) begin
            n_fail++;
            $display("FAIL sop_in_pass: perr=%b valid=%b data=%h sop=%b, want 1/1/502/1",
                     stat_proto_err, o_valid, o_data[31:0], o_sop);
        end
        set_beat(1'b1, 1'b0, 1'b1, 32'h503, '0);
        step();
        n_tests++;
        if (stat_proto_err !== 1'b0 || o_data !== DW'(32'h503) || o_eop !== 1'b1) begin
            n_fail++;
            $display("FAIL frame_eop: perr=%b data=%h eop=%b, want 0/503/1",
                     stat_proto_err, o_data[31:0], o_eop);
        end
        set_beat(1'b1, 1'b0, 1'b1, 32'h504, '0);
        step();
        n_tests++;
        if (stat_proto_err !== 1'b1 || o_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL after_eop_idle: perr=%b valid=%b, want 1/0", stat_proto_err, o_valid);
        end
        cfg_drop_en = 1'b1;
        cfg_drop_threshold = 16'd0;
        set_beat(1'b1, 1'b1, 1'b0, 32'h505, '0);
        step();
        n_tests++;
        if (stat_drop_pulse !== 1'b1 || o_valid !== 1'b0 || stat_drop_pkt_cnt !== 32'd2) begin
            n_fail++;
            $display("FAIL thr0_drop: pulse=%b valid=%b cnt=%0d, want 1/0/2",
                     stat_drop_pulse, o_valid, stat_drop_pkt_cnt);
        end
        cfg_drop_en = 1'b0;
        set_beat(1'b1, 1'b1, 1'b1, 32'h506, '0);
        step();
        n_tests++;
        if (stat_proto_err !== 1'b1 || o_valid !== 1'b1 || o_data !== DW'(32'h506) || stat_drop_pulse !== 1'b0) begin
            n_fail++;
            $display("FAIL sop_in_drop: perr=%b valid=%b data=%h pulse=%b, want 1/1/506/0",
                     stat_proto_err, o_valid, o_data[31:0], stat_drop_pulse);
        end
        set_beat(1'b0, 1'b0, 1'b0, 32'h0, '0);
        step();
    endtask

    task automatic test_saturate_and_reset();
        force dut.r_drop_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.r_drop_cnt;
        cfg_drop_en = 1'b1;
        cfg_drop_threshold = 16'd0;
        o_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_beat(1'b1, 1'b1, 1'b1, 32'h600 + i, '0);
            step();
            n_tests++;
            if (stat_drop_pulse !== 1'b1 || stat_drop_pkt_cnt !== 32'hFFFF_FFFF || o_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL sat_drop%0d: pulse=%b cnt=%h valid=%b, want 1/ffffffff/0",
                         i, stat_drop_pulse, stat_drop_pkt_cnt, o_valid);
            end
        end
        set_beat(1'b0, 1'b0, 1'b0, 32'h0, '0);
        step();
        n_tests++;
        if (stat_drop_pulse !== 1'b0 || stat_drop_pkt_cnt !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL sat_hold: pulse=%b cnt=%h, want 0/ffffffff", stat_drop_pulse, stat_drop_pkt_cnt);
        end

        cfg_drop_en = 1'b0;
        o_ready = 1'b0;
        set_beat(1'b1, 1'b1, 1'b0, 32'h700, '0);
        step();
        n_tests++;
        if (o_valid !== 1'b1 || o_data !== DW'(32'h700)) begin
            n_fail++;
            $display("FAIL rst_pre: valid=%b data=%h, want 1/700", o_valid, o_data[31:0]);
        end
        rst_n = 1'b0;
        set_beat(1'b1, 1'b0, 1'b0, 32'h701, '0);
        #1;
        n_tests++;
        if (i_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_iready: got %b want 0", i_ready);
        end
        step();
        n_tests++;
        if (o_valid !== 1'b0 || o_data !== '0 || stat_drop_pkt_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL rst_mid: valid=%b data=%h cnt=%h, want 0/0/0",
                     o_valid, o_data[31:0], stat_drop_pkt_cnt);
        end
        rst_n = 1'b1;
        o_ready = 1'b1;
        set_beat(1'b1, 1'b0, 1'b1, 32'h702, '0);
        step();
        n_tests++;
        if (stat_proto_err !== 1'b1 || o_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_then_nosop: perr=%b valid=%b, want 1/0", stat_proto_err, o_valid);
        end
        set_beat(1'b0, 1'b0, 1'b0, 32'h0, '0);
        step();
    endtask

    initial begin
        test_reset();
        test_pass();
        test_drop();
        test_mid_packet_cfg();
        test_back_to_back();
        test_framing();
        test_saturate_and_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
